// File: rtl/wb_sdram_responder_if.sv
// wb_sdram_responder_if: Wishbone classic slave bus plus the SDRAM controller's native command/return port.
interface wb_sdram_responder_if #(parameter int WIN_BITS = 23);
  logic                wbs_stb_i;
  logic                wbs_cyc_i;
  logic                wbs_we_i;
  logic [3:0]          wbs_sel_i;
  logic [31:0]         wbs_dat_i;
  logic [31:0]         wbs_adr_i;
  logic                wbs_ack_o;
  logic [31:0]         wbs_dat_o;
  logic                ctrl_in_valid;
  logic                ctrl_rw;
  logic [WIN_BITS-3:0] ctrl_addr;
  logic [31:0]         ctrl_wdata;
  logic [3:0]          ctrl_wmask;
  logic                ctrl_busy;
  logic                ctrl_out_valid;
  logic [31:0]         ctrl_rdata;
  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  ctrl_busy, ctrl_out_valid, ctrl_rdata,
    output wbs_ack_o, wbs_dat_o,
    output ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_wdata, ctrl_wmask
  );
  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output ctrl_busy, ctrl_out_valid, ctrl_rdata,
    input  wbs_ack_o, wbs_dat_o,
    input  ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_wdata, ctrl_wmask
  );
endinterface

// File: rtl/wb_sdram_responder.sv
// wb_sdram_responder: Wishbone classic slave forwarding writes to an SDRAM controller and serving reads from a 4-word line buffer.
module wb_sdram_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h3800_0000,
  parameter int          WIN_BITS   = 23,
  parameter int          LINE_WORDS = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  wb_sdram_responder_if.slave bus
);
  localparam int TW = WIN_BITS - 4;
  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, ACK} state_t;
  state_t              r_state, w_next;
  logic [31:0]         r_buf [LINE_WORDS];
  logic [TW-1:0]       r_tag;
  logic [1:0]          r_icnt, r_rcnt, r_idx;
  logic [WIN_BITS-3:0] r_addr;
  logic [31:0]         r_dat, r_wdata;
  logic [3:0]          r_wmask;
  logic                r_vld, r_ack, r_in_valid, r_rw;
  logic                w_req, w_inr, w_hit, w_ret, w_last, w_wupd, w_unused;
  logic [TW-1:0]       w_atag;
  assign w_req    = bus.wbs_stb_i && bus.wbs_cyc_i && !r_ack;
  assign w_inr    = bus.wbs_adr_i[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS];
  assign w_atag   = bus.wbs_adr_i[WIN_BITS-1:4];
  assign w_hit    = r_vld && w_atag == r_tag;
  // returns are only consumed while a fill is in flight; stale ones after reset fall on the floor
  assign w_ret    = bus.ctrl_out_valid && (r_state == RD_ISSUE || r_state == RD_WAIT);
  assign w_last   = w_ret && r_state == RD_WAIT && r_rcnt == 2'd3;
  assign w_wupd   = r_state == WR && !bus.ctrl_busy && r_vld && r_addr[WIN_BITS-3:2] == r_tag;
  assign w_unused = &{1'b0, bus.wbs_adr_i[1:0]};
  assign bus.wbs_ack_o     = r_ack;
  assign bus.wbs_dat_o     = r_dat;
  assign bus.ctrl_in_valid = r_in_valid;
  assign bus.ctrl_rw       = r_rw;
  assign bus.ctrl_addr     = r_addr;
  assign bus.ctrl_wdata    = r_wdata;
  assign bus.ctrl_wmask    = r_wmask;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = !w_req ? IDLE : !w_inr ? ACK : bus.wbs_we_i ? WR : w_hit ? ACK : RD_ISSUE;
      WR:       w_next = bus.ctrl_busy ? WR : ACK;
      RD_ISSUE: w_next = (!bus.ctrl_busy && r_icnt == 2'd3) ? RD_WAIT : RD_ISSUE;
      RD_WAIT:  w_next = w_last ? ACK : RD_WAIT;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ack      <= 1'b0;
      r_dat      <= '0;
      r_in_valid <= 1'b0;
      r_rw       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_vld      <= 1'b0;
      r_tag      <= '0;
      r_icnt     <= '0;
      r_rcnt     <= '0;
      r_idx      <= '0;
    end else begin
      r_ack <= r_state == ACK && bus.wbs_stb_i && bus.wbs_cyc_i;
      case (r_state)
        IDLE: if (w_req) begin
          if (!w_inr) r_dat <= '0;
          else if (bus.wbs_we_i) begin
            r_in_valid <= 1'b1;
            r_rw       <= 1'b1;
            r_addr     <= bus.wbs_adr_i[WIN_BITS-1:2];
            r_wdata    <= bus.wbs_dat_i;
            r_wmask    <= bus.wbs_sel_i;
          end else if (w_hit) r_dat <= r_buf[bus.wbs_adr_i[3:2]];
          else begin
            r_vld      <= 1'b0;
            r_tag      <= w_atag;
            r_idx      <= bus.wbs_adr_i[3:2];
            r_in_valid <= 1'b1;
            r_rw       <= 1'b0;
            r_addr     <= {w_atag, 2'b00};
            r_icnt     <= '0;
            r_rcnt     <= '0;
          end
        end
        WR: if (!bus.ctrl_busy) r_in_valid <= 1'b0;
        RD_ISSUE: if (!bus.ctrl_busy) begin
          r_icnt <= r_icnt + 2'd1;
          r_addr <= {r_tag, r_icnt + 2'd1};
          if (r_icnt == 2'd3) r_in_valid <= 1'b0;
        end
        RD_WAIT: if (w_last) begin
          r_vld <= 1'b1;
          r_dat <= r_idx == 2'd3 ? bus.ctrl_rdata : r_buf[r_idx];
        end
        default: ;
      endcase
      if (w_ret) r_rcnt <= r_rcnt + 2'd1;
    end
  always_ff @(posedge clk)
    if (w_ret) r_buf[r_rcnt] <= bus.ctrl_rdata;
    else if (w_wupd)
      for (int b = 0; b < 4; b++)
        if (r_wmask[b]) r_buf[r_addr[1:0]][8*b +: 8] <= r_wdata[8*b +: 8];
endmodule

// File: tb/tb_wb_sdram_responder.sv
// tb_wb_sdram_responder: randomized bench with a behavioural SDRAM controller/memory model and a line-residency reference.
module tb_wb_sdram_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  wb_sdram_responder_if #(.WIN_BITS(23)) bus();
  wb_sdram_responder #(.BASE_ADDR(32'h3800_0000), .WIN_BITS(23), .LINE_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0, failures = 0;
  logic [31:0] mem [int];
  int rdq[$];
  int rd_log[$];
  int n_rd = 0, n_wr = 0, iv_cnt = 0, hold_cnt = 0, stab_viol = 0, force_busy = 0;
  int last_wa = -1;
  logic [31:0] last_wd = '0;
  logic [3:0] last_wm = '0;
  bit rand_busy = 0, rand_ret = 0, hold_ret = 0, prev_hold = 0;
  logic [58:0] prev_cmd = '0;
  bit ref_vld = 0;
  int ref_tag = 0;

  function automatic logic [31:0] mem_rd(int a);
    return mem.exists(a) ? mem[a] : 32'(a * 3);
  endfunction

  // controller + memory model: decides busy/returns at negedge, predicts acceptance at the next posedge
  always @(negedge clk) begin
    logic [58:0] cmd;
    logic [31:0] w;
    int a;
    cmd = {bus.ctrl_in_valid, bus.ctrl_rw, bus.ctrl_addr, bus.ctrl_wdata, bus.ctrl_wmask};
    if (prev_hold && rst_n) begin
      hold_cnt++;
      if (cmd !== prev_cmd) stab_viol++;
    end
    if (rdq.size() > 0 && !hold_ret && (!rand_ret || $urandom_range(1, 0) == 1)) begin
      bus.ctrl_out_valid = 1'b1;
      bus.ctrl_rdata = mem_rd(rdq.pop_front());
    end else begin
      bus.ctrl_out_valid = 1'b0;
      bus.ctrl_rdata = $urandom;
    end
    bus.ctrl_busy = force_busy > 0 || (rand_busy && $urandom_range(2, 0) == 0);
    if (force_busy > 0) force_busy--;
    prev_hold = bus.ctrl_in_valid && bus.ctrl_busy;
    prev_cmd = cmd;
    if (rst_n && bus.ctrl_in_valid) iv_cnt++;
    if (rst_n && bus.ctrl_in_valid && !bus.ctrl_busy) begin
      a = int'(bus.ctrl_addr);
      if (bus.ctrl_rw) begin
        w = mem_rd(a);
        for (int b = 0; b < 4; b++) if (bus.ctrl_wmask[b]) w[8*b +: 8] = bus.ctrl_wdata[8*b +: 8];
        mem[a] = w;
        n_wr++;
        last_wa = a;
        last_wd = bus.ctrl_wdata;
        last_wm = bus.ctrl_wmask;
      end else begin
        rdq.push_back(a);
        rd_log.push_back(a);
        n_rd++;
      end
    end
  end

  task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] sel,
                         output logic [31:0] rd, output int ncyc, output bit acked);
    bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = wd;
    bus.wbs_sel_i = sel;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    acked = 0;
    ncyc = 0;
    rd = '0;
    while (!acked && ncyc < 300) begin
      @(posedge clk); #1;
      ncyc++;
      if (bus.wbs_ack_o) begin
        acked = 1;
        rd = bus.wbs_dat_o;
      end
    end
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] got [7];
    string nm [7] = '{"ack", "dat", "in_valid", "rw", "addr", "wdata", "wmask"};
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got = '{32'(bus.wbs_ack_o), bus.wbs_dat_o, 32'(bus.ctrl_in_valid), 32'(bus.ctrl_rw),
            32'(bus.ctrl_addr), bus.ctrl_wdata, 32'(bus.ctrl_wmask)};
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (got[i] !== 32'h0) begin
        failures++;
        $display("FAIL reset_%s got=%0h exp=0", nm[i], got[i]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    int n, iv0;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      iv0 = iv_cnt;
      wb_xfer(k == 1, 32'h3000_0000, 32'h1234_5678, 4'hF, rd, n, ok);
      checks++; if (!ok) begin failures++; $display("FAIL oor_ack%0d got=no_ack exp=ack", k); end
      checks++; if (n !== 2) begin failures++; $display("FAIL oor_latency%0d got=%0d exp=2", k, n); end
      checks++; if (k == 0 && rd !== 32'h0) begin failures++; $display("FAIL oor_data got=%h exp=0", rd); end
      checks++; if (iv_cnt !== iv0) begin failures++; $display("FAIL oor_traffic%0d got=%0d exp=0", k, iv_cnt - iv0); end
    end
  endtask

  task automatic test_miss_hits();
    logic [31:0] rd;
    int n, base;
    bit ok;
    base = rd_log.size();
    wb_xfer(0, 32'h3800_0008, 32'h0, 4'hF, rd, n, ok);
    checks++; if (!ok) begin failures++; $display("FAIL miss_ack got=no_ack exp=ack"); end
    checks++; if (rd !== 32'd6) begin failures++; $display("FAIL miss_data got=%h exp=6", rd); end
    checks++; if (rd_log.size() !== base + 4) begin failures++; $display("FAIL miss_cmds got=%0d exp=4", rd_log.size() - base); end
    if (rd_log.size() >= base + 4)
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rd_log[base+i] !== i) begin failures++; $display("FAIL miss_order%0d got=%0h exp=%0h", i, rd_log[base+i], i); end
      end
    ref_vld = 1; ref_tag = 0;
    base = rd_log.size();
    wb_xfer(0, 32'h3800_000C, 32'h0, 4'hF, rd, n, ok);
    checks++; if (!ok || n !== 2) begin failures++; $display("FAIL hit_latency got=%0d exp=2", n); end
    checks++; if (rd !== 32'd9) begin failures++; $display("FAIL hit_data got=%h exp=9", rd); end
    checks++; if (rd_log.size() !== base) begin failures++; $display("FAIL hit_traffic got=%0d exp=0", rd_log.size() - base); end
  endtask

  task automatic test_write_coherence();
    logic [31:0] rd;
    int n, nw, nr;
    bit ok;
    nw = n_wr; nr = n_rd;
    wb_xfer(1, 32'h3800_0004, 32'hAABB_CCDD, 4'b0011, rd, n, ok);
    checks++; if (!ok || n < 2) begin failures++; $display("FAIL wr_ack got=%0d cycles ok=%0d exp=ack>=2", n, ok); end
    checks++; if (n_wr !== nw + 1) begin failures++; $display("FAIL wr_count got=%0d exp=1", n_wr - nw); end
    checks++; if ({last_wa, last_wd, last_wm} !== {32'd1, 32'hAABB_CCDD, 4'b0011})
      begin failures++; $display("FAIL wr_cmd got=%0h/%h/%b exp=1/aabbccdd/0011", last_wa, last_wd, last_wm); end
    wb_xfer(0, 32'h3800_0004, 32'h0, 4'hF, rd, n, ok);
    checks++; if (!ok || n !== 2) begin failures++; $display("FAIL coh_latency got=%0d exp=2", n); end
    checks++; if (rd !== 32'h0000_CCDD) begin failures++; $display("FAIL coh_data got=%h exp=0000ccdd", rd); end
    checks++; if (n_rd !== nr || n_wr !== nw + 1) begin failures++; $display("FAIL coh_traffic got=rd%0d/wr%0d exp=0/1", n_rd - nr, n_wr - nw); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    logic [31:0] rd = '0;
    bus.wbs_we_i = 1'b0; bus.wbs_adr_i = 32'h3800_0008; bus.wbs_sel_i = 4'hF;
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1;
    while (!bus.wbs_ack_o && n < 50) begin @(posedge clk); #1; n++; end
    rd = bus.wbs_dat_o;
    checks++; if (n !== 2 || rd !== 32'd6) begin failures++; $display("FAIL b2b_first got=%0d/%h exp=2/6", n, rd); end
    @(posedge clk); #1;
    checks++; if (bus.wbs_ack_o !== 1'b0) begin failures++; $display("FAIL b2b_double_ack got=%b exp=0", bus.wbs_ack_o); end
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    int n_base, n, h0, s0;
    bit ok;
    wb_xfer(0, 32'h3800_0100, 32'h0, 4'hF, rd, n_base, ok);
    checks++; if (!ok || rd !== mem_rd(32'h40)) begin failures++; $display("FAIL bp_base_data got=%h exp=%h", rd, mem_rd(32'h40)); end
    h0 = hold_cnt; s0 = stab_viol;
    force_busy = 6;
    wb_xfer(0, 32'h3800_0204, 32'h0, 4'hF, rd, n, ok);
    ref_vld = 1; ref_tag = 32'h20;
    checks++; if (!ok || rd !== mem_rd(32'h81)) begin failures++; $display("FAIL bp_data got=%h exp=%h", rd, mem_rd(32'h81)); end
    checks++; if (n !== n_base + 5) begin failures++; $display("FAIL bp_latency got=%0d exp=%0d", n, n_base + 5); end
    checks++; if (hold_cnt - h0 !== 5) begin failures++; $display("FAIL bp_hold_cycles got=%0d exp=5", hold_cnt - h0); end
    checks++; if (stab_viol !== s0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stab_viol - s0); end
  endtask

  task automatic test_abandon();
    logic [31:0] rd;
    int n = 0, nb, acks = 0;
    bit ok;
    nb = n_rd;
    hold_ret = 1;
    bus.wbs_we_i = 1'b0; bus.wbs_adr_i = 32'h3800_0300; bus.wbs_sel_i = 4'hF;
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1;
    while (n_rd < nb + 4 && n < 50) begin @(posedge clk); #1; n++; end
    checks++; if (n_rd !== nb + 4) begin failures++; $display("FAIL abandon_issue got=%0d exp=4", n_rd - nb); end
    @(posedge clk); #1;
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
    hold_ret = 0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (bus.wbs_ack_o) acks++; end
    checks++; if (acks !== 0) begin failures++; $display("FAIL abandon_ack got=%0d exp=0", acks); end
    checks++; if (rdq.size() !== 0) begin failures++; $display("FAIL abandon_drain got=%0d exp=0", rdq.size()); end
    ref_vld = 1; ref_tag = 32'h30;
    nb = n_rd;
    wb_xfer(0, 32'h3800_030C, 32'h0, 4'hF, rd, n, ok);
    checks++; if (!ok || n !== 2) begin failures++; $display("FAIL abandon_hit_latency got=%0d exp=2", n); end
    checks++; if (rd !== mem_rd(32'hC3)) begin failures++; $display("FAIL abandon_hit_data got=%h exp=%h", rd, mem_rd(32'hC3)); end
    checks++; if (n_rd !== nb) begin failures++; $display("FAIL abandon_hit_traffic got=%0d exp=0", n_rd - nb); end
  endtask

  task automatic test_reset_midfill();
    logic [31:0] got [7];
    logic [31:0] rd;
    int n = 0, nb;
    bit ok;
    nb = n_rd;
    hold_ret = 1;
    bus.wbs_we_i = 1'b0; bus.wbs_adr_i = 32'h3800_0400; bus.wbs_sel_i = 4'hF;
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1;
    while (n_rd < nb + 2 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    got = '{32'(bus.wbs_ack_o), bus.wbs_dat_o, 32'(bus.ctrl_in_valid), 32'(bus.ctrl_rw),
            32'(bus.ctrl_addr), bus.ctrl_wdata, 32'(bus.ctrl_wmask)};
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (got[i] !== 32'h0) begin failures++; $display("FAIL async_reset_out%0d got=%h exp=0", i, got[i]); end
    end
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
    ref_vld = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold_ret = 0;
    n = 0;
    while (rdq.size() > 0 && n < 50) begin @(posedge clk); #1; n++; end
    repeat (2) @(posedge clk);
    #1;
    nb = rd_log.size();
    wb_xfer(0, 32'h3800_0408, 32'h0, 4'hF, rd, n, ok);
    checks++; if (!ok || rd !== mem_rd(32'h102)) begin failures++; $display("FAIL post_reset_data got=%h exp=%h", rd, mem_rd(32'h102)); end
    checks++; if (rd_log.size() !== nb + 4) begin failures++; $display("FAIL post_reset_miss got=%0d exp=4", rd_log.size() - nb); end
    else begin
      checks++;
      if (rd_log[nb] !== 32'h100 || rd_log[nb+3] !== 32'h103)
        begin failures++; $display("FAIL post_reset_addr got=%0h..%0h exp=100..103", rd_log[nb], rd_log[nb+3]); end
    end
    ref_vld = 1; ref_tag = 32'h40;
  endtask

  task automatic test_random();
    logic [31:0] rd, adr, wd, exp;
    logic [3:0] sel;
    int n, word, nr, nw, iv0;
    bit ok, we, oor, hit;
    rand_busy = 1; rand_ret = 1;
    for (int k = 0; k < 60; k++) begin
      oor = $urandom_range(9, 0) == 0;
      word = $urandom_range(31, 0) | ($urandom_range(1, 0) << 20);
      adr = oor ? 32'h3880_0000 + ($urandom_range(1023, 0) << 2) : 32'h3800_0000 + 32'(word * 4);
      we = $urandom_range(2, 0) == 0;
      sel = 4'($urandom_range(15, 1));
      wd = $urandom;
      exp = mem_rd(word);
      hit = ref_vld && ref_tag == (word >> 2);
      nr = n_rd; nw = n_wr; iv0 = iv_cnt;
      wb_xfer(we, adr, wd, sel, rd, n, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rnd%0d_ack adr=%h got=no_ack exp=ack", k, adr); end
      if (oor) begin
        checks++; if (iv_cnt !== iv0 || (!we && rd !== 32'h0))
          begin failures++; $display("FAIL rnd%0d_oor adr=%h got=%h/%0d exp=0/0", k, adr, rd, iv_cnt - iv0); end
      end else if (we) begin
        checks++; if (n_wr !== nw + 1 || n_rd !== nr || {last_wa, last_wd, last_wm} !== {word, wd, sel})
          begin failures++; $display("FAIL rnd%0d_write got=%0h/%h/%b exp=%0h/%h/%b", k, last_wa, last_wd, last_wm, word, wd, sel); end
      end else begin
        checks++; if (rd !== exp) begin failures++; $display("FAIL rnd%0d_rdata adr=%h got=%h exp=%h", k, adr, rd, exp); end
        if (hit) begin
          checks++; if (n !== 2 || n_rd !== nr) begin failures++; $display("FAIL rnd%0d_hit got=%0d/%0d exp=2/0", k, n, n_rd - nr); end
        end else begin
          checks++; if (n_rd !== nr + 4 || rd_log.size() < nr + 1 || rd_log[nr] !== (word & ~3))
            begin failures++; $display("FAIL rnd%0d_miss got=%0d cmds exp=4 from %0h", k, n_rd - nr, word & ~3); end
          ref_vld = 1; ref_tag = word >> 2;
        end
      end
    end
    rand_busy = 0; rand_ret = 0;
  endtask

  initial begin
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_dat_i = 32'h0; bus.wbs_adr_i = 32'h0;
    test_reset();
    test_out_of_range();
    test_miss_hits();
    test_write_coherence();
    test_back_to_back();
    test_backpressure();
    test_abandon();
    test_reset_midfill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
